// File: rtl/ws2812_pkg.sv
// ---------------------------------------------------------------------------
// ws2812_pkg
// Shared definitions for the WS2812 frame controller:
//   ADDR_W    - width of the LED buffer pixel index
//   RGB_W     - width of one GRB pixel word
//   state_t   - frame controller state encoding
//   cnt_width - bits needed for a down/up counter holding 0..max_val
// ---------------------------------------------------------------------------
package ws2812_pkg;

   localparam int ADDR_W = 9;
   localparam int RGB_W  = 24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_PRESENT,
      ST_DRAIN,
      ST_LATCH,
      ST_DONE
   } state_t;

   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ws2812_latch_timer.sv
// ---------------------------------------------------------------------------
// ws2812_latch_timer
// Times the line-low latch interval. A load pulse arms the counter with
// CYCLES-1; it counts down once per clock and raises expire during the
// last cycle of the interval, then disarms itself.
// Ports:
//   clk    - sole clock, rising edge
//   rst_n  - asynchronous active-low reset
//   load   - start a new interval (issued in the cycle before the interval)
//   expire - high during the final cycle of the interval
// ---------------------------------------------------------------------------
module ws2812_latch_timer
   import ws2812_pkg::*;
#(
   parameter int CYCLES = 28000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic expire
);

   localparam int CNT_W = cnt_width(CYCLES);

   logic [CNT_W-1:0] cnt_reg;
   logic             run_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         run_reg <= 1'b0;
      end else if (load) begin
         cnt_reg <= CNT_W'(CYCLES - 1);
         run_reg <= 1'b1;
      end else if (run_reg) begin
         if (cnt_reg == '0) begin
            run_reg <= 1'b0;
         end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
         end
      end
   end

   assign expire = run_reg && (cnt_reg == '0);

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// ---------------------------------------------------------------------------
// ws2812_frame_ctrl
// Walks the LED buffer one pixel at a time, hands each pixel to the bit
// serializer, waits for the serializer to drain, then holds the line low for
// the latch interval and reports the end of the frame.
// Ports:
//   clk, rst_n         - clock (rising edge) and asynchronous active-low reset
//   start              - frame request, honoured only while idle
//   auto_refresh       - restart a new frame after each latch (sampled at end)
//   mem_read_en        - read request to LED buffer, held until mem_data_dv
//   mem_read_address   - pixel index being read
//   mem_rgb_data       - pixel word from LED buffer
//   mem_data_dv        - one-cycle valid for mem_rgb_data
//   pix_valid/pix_data - pixel offered to serializer (valid/ready)
//   pix_ready          - serializer accepts pixel
//   tx_idle            - serializer has shifted out everything
//   latch_active       - high during the latch interval
//   busy               - high whenever not idle
//   frame_done         - one-cycle pulse after the latch interval
//   rd_err             - sticky buffer read timeout flag (cleared by reset)
// All outputs are registers loaded from the next-state decode, so each output
// changes in the same cycle as the state it describes.
// ---------------------------------------------------------------------------
module ws2812_frame_ctrl
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS     = 300,
   parameter int LATCH_CYCLES = 28000,
   parameter int DV_TIMEOUT   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              auto_refresh,
   output logic              mem_read_en,
   output logic [ADDR_W-1:0] mem_read_address,
   input  logic [RGB_W-1:0]  mem_rgb_data,
   input  logic              mem_data_dv,
   output logic              pix_valid,
   output logic [RGB_W-1:0]  pix_data,
   input  logic              pix_ready,
   input  logic              tx_idle,
   output logic              latch_active,
   output logic              busy,
   output logic              frame_done,
   output logic              rd_err
);

   localparam int                DV_W     = cnt_width(DV_TIMEOUT);
   localparam logic [DV_W-1:0]   DV_LAST  = DV_W'(DV_TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] index_reg, index_next;
   logic [DV_W-1:0]   dv_cnt_reg, dv_cnt_next;
   logic              dv_timeout;
   logic              latch_load;
   logic              latch_expire;

   logic              mem_read_en_reg, mem_read_en_next;
   logic [ADDR_W-1:0] mem_read_address_reg, mem_read_address_next;
   logic              pix_valid_reg, pix_valid_next;
   logic [RGB_W-1:0]  pix_data_reg, pix_data_next;
   logic              latch_active_reg, latch_active_next;
   logic              busy_reg, busy_next;
   logic              frame_done_reg, frame_done_next;
   logic              rd_err_reg, rd_err_next;

   ws2812_latch_timer #(
      .CYCLES (LATCH_CYCLES)
   ) u_latch_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (latch_load),
      .expire (latch_expire)
   );

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg            <= ST_IDLE;
         index_reg            <= '0;
         dv_cnt_reg           <= '0;
         mem_read_en_reg      <= 1'b0;
         mem_read_address_reg <= '0;
         pix_valid_reg        <= 1'b0;
         pix_data_reg         <= '0;
         latch_active_reg     <= 1'b0;
         busy_reg             <= 1'b0;
         frame_done_reg       <= 1'b0;
         rd_err_reg           <= 1'b0;
      end else begin
         state_reg            <= state_next;
         index_reg            <= index_next;
         dv_cnt_reg           <= dv_cnt_next;
         mem_read_en_reg      <= mem_read_en_next;
         mem_read_address_reg <= mem_read_address_next;
         pix_valid_reg        <= pix_valid_next;
         pix_data_reg         <= pix_data_next;
         latch_active_reg     <= latch_active_next;
         busy_reg             <= busy_next;
         frame_done_reg       <= frame_done_next;
         rd_err_reg           <= rd_err_next;
      end
   end

   // Next-state decode
   always_comb begin
      state_next  = state_reg;
      index_next  = index_reg;
      dv_cnt_next = dv_cnt_reg;
      dv_timeout  = 1'b0;
      latch_load  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next  = ST_FETCH;
               index_next  = '0;
               dv_cnt_next = '0;
            end
         end
         ST_FETCH: begin
            if (mem_data_dv) begin
               state_next  = ST_PRESENT;
               dv_cnt_next = '0;
            end else if (dv_cnt_reg == DV_LAST) begin
               // Buffer never answered: abort the frame but still latch
               dv_timeout  = 1'b1;
               state_next  = ST_DRAIN;
               index_next  = '0;
               dv_cnt_next = '0;
            end else begin
               dv_cnt_next = dv_cnt_reg + DV_W'(1);
            end
         end
         ST_PRESENT: begin
            if (pix_valid_reg && pix_ready) begin
               dv_cnt_next = '0;
               if (index_reg == LAST_IDX) begin
                  index_next = '0;
                  state_next = ST_DRAIN;
               end else begin
                  index_next = index_reg + ADDR_W'(1);
                  state_next = ST_FETCH;
               end
            end
         end
         ST_DRAIN: begin
            if (tx_idle) begin
               latch_load = 1'b1;
               state_next = ST_LATCH;
            end
         end
         ST_LATCH: begin
            if (latch_expire) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            index_next  = '0;
            dv_cnt_next = '0;
            state_next  = auto_refresh ? ST_FETCH : ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
            index_next = '0;
         end
      endcase
   end

   // Output decode, evaluated on the state being entered
   always_comb begin
      mem_read_en_next      = (state_next == ST_FETCH);
      mem_read_address_next = index_next;
      pix_valid_next        = (state_next == ST_PRESENT);
      pix_data_next         = pix_data_reg;
      if ((state_reg == ST_FETCH) && mem_data_dv) begin
         pix_data_next = mem_rgb_data;
      end
      latch_active_next     = (state_next == ST_LATCH);
      busy_next             = (state_next != ST_IDLE);
      frame_done_next       = (state_next == ST_DONE);
      rd_err_next           = rd_err_reg | dv_timeout;
   end

   assign mem_read_en      = mem_read_en_reg;
   assign mem_read_address = mem_read_address_reg;
   assign pix_valid        = pix_valid_reg;
   assign pix_data         = pix_data_reg;
   assign latch_active     = latch_active_reg;
   assign busy             = busy_reg;
   assign frame_done       = frame_done_reg;
   assign rd_err           = rd_err_reg;

endmodule
